// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants and the scan-code prefix state.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_SP  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } prefix_state_t;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Scan-code input and key FIFO read port of the PS/2 key decoder.
interface ps2_key_decoder_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          code_tick;
    logic [7:0]    code;
    logic          key_valid;
    logic [7:0]    key_data;
    logic          key_pop;
    logic [AW:0]   count;
    logic          overflow;
    logic          shift_on;
    logic          caps_on;

    modport master (
        output code_tick, code, key_pop,
        input  key_valid, key_data, count, overflow, shift_on, caps_on
    );

    modport slave (
        input  code_tick, code, key_pop,
        output key_valid, key_data, count, overflow, shift_on, caps_on
    );

endinterface

// File: rtl/ps2_ascii_map.sv
// Combinational set-2 make-code to ASCII translation; hit=0 for unmapped codes.
module ps2_ascii_map
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       upper,
    output logic [7:0] ascii,
    output logic       hit
);

    always_comb begin
        ascii = 8'h00;
        hit   = 1'b1;
        case (code)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = ASCII_SP;
            8'h5A: ascii = ASCII_CR;
            8'h66: ascii = ASCII_BS;
            default: hit = 1'b0;
        endcase
        // Only letters take case; digits and controls ignore shift
        if (upper && (ascii >= 8'h61) && (ascii <= 8'h7A)) begin
            ascii = ascii - 8'h20;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: prefix FSM, Shift/Caps tracking and a FWFT ASCII key FIFO.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    ps2_key_decoder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    prefix_state_t state;
    logic          lshift_q;
    logic          rshift_q;
    logic          caps_q;
    logic          overflow_q;
    logic          key_valid_q;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_nxt;
    logic [7:0]    mem [DEPTH];

    logic          upper_c;
    logic [7:0]    map_ascii;
    logic          map_hit;
    logic          is_make;
    logic          is_break;
    logic          full;
    logic          pop_ok;
    logic          push;
    logic          push_ok;

    // Case uses the modifier state registered before this tick
    assign upper_c = (lshift_q | rshift_q) ^ caps_q;

    ps2_ascii_map u_map (
        .code  (bus.code),
        .upper (upper_c),
        .ascii (map_ascii),
        .hit   (map_hit)
    );

    assign is_make  = bus.code_tick && (state == ST_IDLE) &&
                      (bus.code != SC_BREAK) && (bus.code != SC_EXT);
    assign is_break = bus.code_tick && (state == ST_BRK);

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign pop_ok    = bus.key_pop && (count_q != '0);
    assign push      = is_make && map_hit;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push_ok   = push && (!full || pop_ok);
    assign count_nxt = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    // Prefix FSM and modifier state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            caps_q   <= 1'b0;
        end else if (bus.code_tick) begin
            case (state)
                ST_IDLE: begin
                    if (bus.code == SC_BREAK)     state <= ST_BRK;
                    else if (bus.code == SC_EXT)  state <= ST_EXT;
                    else                          state <= ST_IDLE;
                end
                ST_BRK:  state <= ST_IDLE;
                ST_EXT:  state <= (bus.code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (is_make) begin
                if (bus.code == SC_LSHIFT) lshift_q <= 1'b1;
                if (bus.code == SC_RSHIFT) rshift_q <= 1'b1;
                if (bus.code == SC_CAPS)   caps_q   <= ~caps_q;
            end
            if (is_break) begin
                if (bus.code == SC_LSHIFT) lshift_q <= 1'b0;
                if (bus.code == SC_RSHIFT) rshift_q <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_ok)        wr_ptr     <= wr_ptr + AW'(1);
            if (pop_ok)         rd_ptr     <= rd_ptr + AW'(1);
            if (push && !push_ok) overflow_q <= 1'b1;
            count_q     <= count_nxt;
            key_valid_q <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= map_ascii;
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_data  = key_valid_q ? mem[rd_ptr] : 8'h00;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.shift_on  = lshift_q | rshift_q;
    assign bus.caps_on   = caps_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a queue-based key model.
module tb_ps2_key_decoder;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    ps2_key_decoder_if #(.DEPTH(DEPTH)) bus ();

    ps2_key_decoder #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // Reference model state
    logic [7:0] q [$];
    bit m_ls, m_rs, m_caps, m_ovf, m_ext, m_brk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int xlate(input logic [7:0] c, input bit up);
        for (int i = 0; i < 26; i++) if (let_sc[i] == c) return (up ? 65 : 97) + i;
        for (int i = 0; i < 10; i++) if (dig_sc[i] == c) return 48 + i;
        if (c == 8'h29) return 32;
        if (c == 8'h5A) return 13;
        if (c == 8'h66) return 8;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ls = 0; m_rs = 0; m_caps = 0; m_ovf = 0; m_ext = 0; m_brk = 0;
    endtask

    task automatic model_make(input logic [7:0] c);
        int a;
        a = xlate(c, (m_ls | m_rs) ^ m_caps);
        if (c == 8'h12) m_ls = 1;
        if (c == 8'h59) m_rs = 1;
        if (c == 8'h58) m_caps = !m_caps;
        if (a >= 0) begin
            if (q.size() < DEPTH) q.push_back(8'(a));
            else m_ovf = 1;
        end
    endtask

    task automatic model_apply(input bit t, input logic [7:0] c, input bit p);
        if (p && q.size() != 0) void'(q.pop_front());
        if (t) begin
            if (!m_ext && !m_brk) begin
                if (c == 8'hF0)      m_brk = 1;
                else if (c == 8'hE0) m_ext = 1;
                else                 model_make(c);
            end else if (!m_ext) begin
                if (c == 8'h12) m_ls = 0;
                if (c == 8'h59) m_rs = 0;
                m_brk = 0;
            end else if (!m_brk) begin
                if (c == 8'hF0) m_brk = 1;
                else            m_ext = 0;
            end else begin
                m_ext = 0; m_brk = 0;
            end
        end
    endtask

    task automatic check_model();
        check("key_valid", bus.key_valid, q.size() != 0);
        check("count", bus.count, q.size());
        if (q.size() != 0) check("key_data", bus.key_data, q[0]);
        check("overflow", bus.overflow, m_ovf);
        check("shift_on", bus.shift_on, m_ls | m_rs);
        check("caps_on", bus.caps_on, m_caps);
    endtask

    task automatic step(input bit t, input logic [7:0] c, input bit p);
        @(negedge clk);
        check_model();
        bus.code_tick = t;
        bus.code      = c;
        bus.key_pop   = p;
        @(posedge clk);
        model_apply(t, c, p);
        #1;
        bus.code_tick = 1'b0;
        bus.key_pop   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.key_valid, 0);
        check({tag, "_data"}, bus.key_data, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_ovf"}, bus.overflow, 0);
        check({tag, "_shift"}, bus.shift_on, 0);
        check({tag, "_caps"}, bus.caps_on, 0);
    endtask

    initial begin
        logic [7:0] c;
        int r;
        reset = 1'b0;
        bus.code_tick = 1'b0;
        bus.code      = 8'h00;
        bus.key_pop   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst0");
        @(negedge clk) reset = 1'b1;

        // Single make/break of 'a'
        step(1, 8'h1C, 0);
        check("a_valid_lat", bus.key_valid, 1);
        step(1, 8'hF0, 0); step(1, 8'h1C, 0);
        check("a_one_entry", bus.count, 1);
        check("a_data", bus.key_data, 8'h61);
        step(0, 8'h00, 1);
        check("a_popped", bus.key_valid, 0);

        // Shift held / released
        step(1, 8'h12, 0);
        check("shift_set", bus.shift_on, 1);
        step(1, 8'h1C, 0); step(1, 8'hF0, 0); step(1, 8'h12, 0);
        check("shift_clr", bus.shift_on, 0);
        step(1, 8'h1C, 0);
        check("sh_head", bus.key_data, 8'h41);
        step(0, 8'h00, 1);
        check("sh_second", bus.key_data, 8'h61);
        step(0, 8'h00, 1);

        // Caps XOR Shift, digit ignores shift
        step(1, 8'h58, 0); step(1, 8'h1C, 0); step(1, 8'h12, 0); step(1, 8'h1C, 0);
        step(1, 8'h16, 0);
        check("caps_cnt", bus.count, 3);
        check("caps_head", bus.key_data, 8'h41);
        step(0, 8'h00, 1);
        check("caps_xor", bus.key_data, 8'h61);
        step(0, 8'h00, 1);
        check("digit", bus.key_data, 8'h31);
        step(0, 8'h00, 1);
        step(1, 8'hF0, 0); step(1, 8'h58, 0);
        check("caps_brk_noop", bus.caps_on, 1);
        step(1, 8'hF0, 0); step(1, 8'h12, 0); step(1, 8'h58, 0);
        check("caps_off", bus.caps_on, 0);

        // Extended codes and unmapped make are discarded
        step(1, 8'hE0, 0); step(1, 8'h75, 0);
        step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h75, 0);
        step(1, 8'h0E, 0);
        check("ext_none", bus.count, 0);
        step(1, 8'h29, 0);
        check("space", bus.key_data, 8'h20);
        step(0, 8'h00, 1);

        // Fill past DEPTH, then push+pop while full
        for (int i = 0; i < 9; i++) step(1, let_sc[i], 0);
        check("full_cnt", bus.count, DEPTH);
        check("full_ovf", bus.overflow, 1);
        check("full_head", bus.key_data, 8'h61);
        step(1, 8'h1A, 1);
        check("pp_cnt", bus.count, DEPTH);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 1);
        check("pp_last", bus.key_data, 8'h7A);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        check("pop_empty", bus.count, 0);

        // Reset mid-prefix discards pending F0
        step(1, 8'hF0, 0);
        @(negedge clk) reset = 1'b0;
        #1 check_reset_outputs("rst1");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst2");
        @(negedge clk) reset = 1'b1;
        model_reset();
        step(1, 8'h1C, 0);
        check("rst_prefix", bus.key_data, 8'h61);

        // Random stream against the model
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      c = let_sc[$urandom_range(0, 25)];
            else if (r < 55) c = dig_sc[$urandom_range(0, 9)];
            else if (r < 65) c = 8'hF0;
            else if (r < 70) c = 8'hE0;
            else if (r < 80) c = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            else if (r < 85) c = 8'h58;
            else if (r < 90) c = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h5A;
            else             c = 8'($urandom_range(0, 255));
            step($urandom_range(0, 1) != 0, c, $urandom_range(0, 9) < 3);
        end
        @(negedge clk);
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
